branch_predict_pc: RTL and testbench

//  Fetch-stage program counter with dynamic branch prediction: direct-mapped branch target buffer (BTB)

---
 rtl/pc_pkg.sv | 20 ++
 rtl/branch_cond_eval.sv | 34 +++
 rtl/branch_predict_pc.sv | 124 ++++++++++++
 tb/tb_branch_predict_pc.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants for the fetch-stage PC / branch predictor: address width,
// branch condition codes and flag bit positions within {Z,V,N}.
package pc_pkg;

    localparam int unsigned ADDR_W_DEF = 16;

    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GE  = 3'b100;
    localparam logic [2:0] CC_LE  = 3'b101;
    localparam logic [2:0] CC_OV  = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation: 3-bit condition code against
// the {Z,V,N} flag register.
module branch_cond_eval
    import pc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z;
    logic v;
    logic n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (ccc)
            CC_NE:   taken = ~z;
            CC_EQ:   taken = z;
            CC_GT:   taken = ~z & ~n;
            CC_LT:   taken = n;
            CC_GE:   taken = z | ~n;
            CC_LE:   taken = z | n;
            CC_OV:   taken = v;
            CC_UNC:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_pc.sv
// Fetch-stage PC with a direct-mapped BTB and per-entry saturating counters;
// resolves B/BR in EX and redirects/flushes on a mispredicted next PC.
module branch_predict_pc
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned OFF_W       = 9,
    parameter int unsigned BTB_ENTRIES = 8,
    parameter int unsigned CTR_W       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              ex_valid,
    input  logic              ex_branch,
    input  logic              ex_br,
    input  logic [2:0]        ex_ccc,
    input  logic [2:0]        ex_flags,
    input  logic [OFF_W-1:0]  ex_imm,
    input  logic [ADDR_W-1:0] ex_rs,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic              flush
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 1;
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = {1'b1, {(CTR_W-1){1'b0}}};

    logic              btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
    logic [ADDR_W-1:0] btb_target [BTB_ENTRIES];
    logic [CTR_W-1:0]  ctr        [BTB_ENTRIES];

    logic [IDX_W-1:0]  f_idx;
    logic [TAG_W-1:0]  f_tag;
    logic              f_hit;
    logic [ADDR_W-1:0] pc_inc;

    logic [IDX_W-1:0]  e_idx;
    logic [TAG_W-1:0]  e_tag;
    logic              e_hit;
    logic              resolve;
    logic              taken;
    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] ex_pc_inc;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] actual_next;
    logic              mispredict;
    logic [CTR_W-1:0]  e_ctr;

    // The carried prediction bit is redundant: the target alone decides mispredict.
    logic unused_pred_taken;
    assign unused_pred_taken = ex_pred_taken;

    assign f_idx       = pc[IDX_W:1];
    assign f_tag       = pc[ADDR_W-1:IDX_W+1];
    assign pc_inc      = pc + ADDR_W'(2);
    assign f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    assign pred_taken  = f_hit & ctr[f_idx][CTR_W-1];
    assign pred_target = pred_taken ? btb_target[f_idx] : pc_inc;

    branch_cond_eval u_cond (
        .ccc   (ex_ccc),
        .flags (ex_flags),
        .taken (taken)
    );

    assign e_idx       = ex_pc[IDX_W:1];
    assign e_tag       = ex_pc[ADDR_W-1:IDX_W+1];
    assign e_hit       = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
    assign e_ctr       = ctr[e_idx];
    assign resolve     = ex_valid & ex_branch;
    assign off_ext     = {{(ADDR_W-OFF_W){ex_imm[OFF_W-1]}}, ex_imm};
    assign ex_pc_inc   = ex_pc + ADDR_W'(2);
    assign br_target   = ex_br ? ex_rs : ex_pc_inc + {off_ext[ADDR_W-2:0], 1'b0};
    assign actual_next = taken ? br_target : ex_pc_inc;
    assign mispredict  = resolve && (actual_next != ex_pred_target);
    assign flush       = mispredict;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (mispredict) begin
            pc <= actual_next;
        end else if (!stall) begin
            pc <= pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                ctr[i]       <= CTR_WEAK_NT;
            end
        end else if (resolve) begin
            if (taken) begin
                btb_valid[e_idx] <= 1'b1;
                if (!e_hit) begin
                    ctr[e_idx] <= CTR_WEAK_T;
                end else if (e_ctr != '1) begin
                    ctr[e_idx] <= e_ctr + CTR_W'(1);
                end
            end else if (e_ctr != '0) begin
                ctr[e_idx] <= e_ctr - CTR_W'(1);
            end
        end
    end

    // Tag/target need no reset: they are only observed through a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && resolve && taken) begin
            btb_tag[e_idx]    <= e_tag;
            btb_target[e_idx] <= br_target;
        end
    end

endmodule

// File: tb/tb_branch_predict_pc.sv
// Self-checking bench for branch_predict_pc: directed scenarios plus random
// traffic compared against a behavioural predictor model.
module tb_branch_predict_pc;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [15:0] pc;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_br;
    logic [2:0]  ex_ccc;
    logic [2:0]  ex_flags;
    logic [8:0]  ex_imm;
    logic [15:0] ex_rs;
    logic [15:0] ex_pc;
    logic        ex_pred_taken;
    logic [15:0] ex_pred_target;
    logic        flush;

    int checks = 0;
    int errors = 0;

    // Behavioural model: 8-entry table indexed by halfword number mod 8.
    logic [15:0] m_pc;
    bit          m_valid [8];
    int          m_tag   [8];
    logic [15:0] m_tgt   [8];
    int          m_ctr   [8];

    branch_predict_pc #(
        .ADDR_W      (16),
        .OFF_W       (9),
        .BTB_ENTRIES (8),
        .CTR_W       (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_br          (ex_br),
        .ex_ccc         (ex_ccc),
        .ex_flags       (ex_flags),
        .ex_imm         (ex_imm),
        .ex_rs          (ex_rs),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .flush          (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int slot(input logic [15:0] a);
        return (int'(a) / 2) % 8;
    endfunction

    function automatic int tag_of(input logic [15:0] a);
        return int'(a) / 16;
    endfunction

    function automatic bit m_pred_taken(input logic [15:0] a);
        return m_valid[slot(a)] && (m_tag[slot(a)] == tag_of(a)) && (m_ctr[slot(a)] >= 2);
    endfunction

    function automatic logic [15:0] m_pred_target(input logic [15:0] a);
        if (m_pred_taken(a)) return m_tgt[slot(a)];
        return 16'((int'(a) + 2) % 65536);
    endfunction

    function automatic bit m_cond(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (int'(c))
            0: return !z;
            1: return z;
            2: return !z && !n;
            3: return n;
            4: return z || !n;
            5: return z || n;
            6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] m_jump_target();
        int simm;
        if (ex_br) return ex_rs;
        simm = int'(ex_imm);
        if (simm >= 256) simm = simm - 512;
        return 16'((int'(ex_pc) + 2 + 2 * simm + 65536 * 4) % 65536);
    endfunction

    function automatic logic [15:0] m_actual_next();
        if (m_cond(ex_ccc, ex_flags)) return m_jump_target();
        return 16'((int'(ex_pc) + 2) % 65536);
    endfunction

    function automatic bit m_flush();
        return ex_valid && ex_branch && (m_actual_next() != ex_pred_target);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endtask

    // Advance one clock: compute model next state from pre-edge inputs, then commit.
    task automatic tick();
        logic [15:0] nx;
        int s;
        bit hit;
        if (rst) begin
            nx = 16'h0000;
            model_reset();
        end else begin
            if (m_flush()) nx = m_actual_next();
            else if (stall) nx = m_pc;
            else nx = m_pred_target(m_pc);
            if (ex_valid && ex_branch) begin
                s   = slot(ex_pc);
                hit = m_valid[s] && (m_tag[s] == tag_of(ex_pc));
                if (m_cond(ex_ccc, ex_flags)) begin
                    m_ctr[s]   = hit ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3) : 2;
                    m_valid[s] = 1'b1;
                    m_tag[s]   = tag_of(ex_pc);
                    m_tgt[s]   = m_jump_target();
                end else if (m_ctr[s] > 0) begin
                    m_ctr[s] = m_ctr[s] - 1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_pc = nx;
    endtask

    task automatic clear_ex();
        ex_valid = 0; ex_branch = 0; ex_br = 0; ex_ccc = 0; ex_flags = 0;
        ex_imm = 0; ex_rs = 0; ex_pc = 0; ex_pred_taken = 0; ex_pred_target = 0;
    endtask

    task automatic drive_br(input logic [15:0] at, input logic [15:0] rs, input logic [15:0] ptgt);
        ex_valid = 1; ex_branch = 1; ex_br = 1; ex_ccc = 3'b111; ex_flags = 0;
        ex_imm = 0; ex_rs = rs; ex_pc = at; ex_pred_taken = 0; ex_pred_target = ptgt;
    endtask

    task automatic test_reset();
        rst = 1; stall = 0; clear_ex();
        tick(); tick();
        checks++;
        if (pc !== 16'h0000 || pred_taken !== 1'b0 || pred_target !== 16'h0002 || flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h pt=%b tgt=%h fl=%b req 0000 0 0002 0", pc, pred_taken, pred_target, flush);
        end
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (pc !== 16'(2 * k) || pc !== m_pc || pred_taken !== 1'b0 || flush !== 1'b0) begin
                errors++;
                $display("FAIL seq_pc k=%0d pc=%h pt=%b fl=%b req %h 0 0", k, pc, pred_taken, flush, 16'(2 * k));
            end
            tick();
        end
    endtask

    task automatic test_taken_alloc();
        ex_valid = 1; ex_branch = 1; ex_br = 0; ex_ccc = 3'b111; ex_flags = 0;
        ex_imm = 9'd3; ex_pc = 16'h0010; ex_pred_taken = 0; ex_pred_target = 16'h0012;
        #1;
        checks++;
        if (flush !== 1'b1 || flush !== m_flush()) begin
            errors++;
            $display("FAIL b_taken_flush flush=%b req 1", flush);
        end
        tick();
        checks++;
        if (pc !== 16'h0018 || pc !== m_pc) begin
            errors++;
            $display("FAIL b_taken_pc pc=%h req 0018", pc);
        end
        drive_br(16'h0044, 16'h0010, 16'h0046);
        tick();
        clear_ex();
        #1;
        checks++;
        if (pc !== 16'h0010 || pred_taken !== 1'b1 || pred_target !== 16'h0018) begin
            errors++;
            $display("FAIL btb_hit pc=%h pt=%b tgt=%h req 0010 1 0018", pc, pred_taken, pred_target);
        end
    endtask

    task automatic test_not_taken();
        ex_valid = 1; ex_branch = 1; ex_br = 0; ex_ccc = 3'b001; ex_flags = 3'b000;
        ex_imm = 9'd3; ex_pc = 16'h0010; ex_pred_taken = 1; ex_pred_target = 16'h0018;
        #1;
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL nt_flush flush=%b req 1", flush);
        end
        tick();
        checks++;
        if (pc !== 16'h0012 || pc !== m_pc) begin
            errors++;
            $display("FAIL nt_pc pc=%h req 0012", pc);
        end
        drive_br(16'h0044, 16'h0010, 16'h0046);
        tick();
        clear_ex();
        #1;
        checks++;
        if (pc !== 16'h0010 || pred_taken !== 1'b0 || pred_target !== 16'h0012) begin
            errors++;
            $display("FAIL ctr_weakened pc=%h pt=%b tgt=%h req 0010 0 0012", pc, pred_taken, pred_target);
        end
    endtask

    task automatic test_stall_redirect();
        stall = 1;
        drive_br(16'h0050, 16'h1234, 16'h0052);
        #1;
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL stall_flush flush=%b req 1", flush);
        end
        tick();
        checks++;
        if (pc !== 16'h1234) begin
            errors++;
            $display("FAIL stall_redirect pc=%h req 1234", pc);
        end
        clear_ex();
        tick();
        checks++;
        if (pc !== 16'h1234 || flush !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold pc=%h fl=%b req 1234 0", pc, flush);
        end
        stall = 0;
    endtask

    task automatic test_wrap();
        drive_br(16'h0070, 16'hFFFE, 16'h0072);
        tick();
        clear_ex();
        checks++;
        if (pc !== 16'hFFFE || pred_target !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_target pc=%h tgt=%h req FFFE 0000", pc, pred_target);
        end
        tick();
        checks++;
        if (pc !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_pc pc=%h req 0000", pc);
        end
    endtask

    task automatic test_cond_table();
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                ex_valid = 1; ex_branch = 1; ex_br = 0; ex_ccc = 3'(c); ex_flags = 3'(f);
                ex_imm = 9'h1FF; ex_pc = 16'h0000; ex_pred_taken = 0; ex_pred_target = 16'h0002;
                #1;
                checks++;
                if (flush !== m_flush()) begin
                    errors++;
                    $display("FAIL cond ccc=%0d flags=%b flush=%b req %b", c, 3'(f), flush, m_flush());
                end
            end
        end
        ex_ccc = 3'b111;
        tick();
        clear_ex();
        checks++;
        if (pc !== 16'h0000 || pc !== m_pc) begin
            errors++;
            $display("FAIL neg_offset pc=%h req 0000", pc);
        end
    endtask

    task automatic test_alias();
        drive_br(16'h0002, 16'h0100, 16'h0004);
        tick();
        drive_br(16'h0060, 16'h0012, 16'h0062);
        tick();
        clear_ex();
        checks++;
        if (pc !== 16'h0012 || pred_taken !== 1'b0 || pred_target !== 16'h0014) begin
            errors++;
            $display("FAIL alias_nohit pc=%h pt=%b tgt=%h req 0012 0 0014", pc, pred_taken, pred_target);
        end
        drive_br(16'h0060, 16'h0002, 16'h0062);
        tick();
        clear_ex();
        checks++;
        if (pc !== 16'h0002 || pred_taken !== 1'b1 || pred_target !== 16'h0100) begin
            errors++;
            $display("FAIL alias_hit pc=%h pt=%b tgt=%h req 0002 1 0100", pc, pred_taken, pred_target);
        end
        rst = 1;
        tick();
        rst = 0;
        tick();
        checks++;
        if (pc !== 16'h0002 || pred_taken !== 1'b0 || pred_target !== 16'h0004) begin
            errors++;
            $display("FAIL rst_clears pc=%h pt=%b tgt=%h req 0002 0 0004", pc, pred_taken, pred_target);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(99) == 0);
            stall     = ($urandom_range(3) == 0);
            ex_valid  = ($urandom_range(9) < 7);
            ex_branch = ($urandom_range(9) < 7);
            ex_br     = ($urandom_range(9) < 3);
            ex_ccc    = 3'($urandom_range(7));
            ex_flags  = 3'($urandom_range(7));
            ex_imm    = 9'($urandom_range(511));
            ex_rs     = 16'($urandom_range(255) * 2);
            ex_pc     = 16'($urandom_range(47) * 2);
            if ($urandom_range(1) == 1) begin
                ex_pred_taken  = m_pred_taken(ex_pc);
                ex_pred_target = m_pred_target(ex_pc);
            end else begin
                ex_pred_taken  = $urandom_range(1) == 1;
                ex_pred_target = 16'($urandom_range(255) * 2);
            end
            #1;
            checks++;
            if (pc !== m_pc || pred_taken !== m_pred_taken(m_pc) ||
                pred_target !== m_pred_target(m_pc) || flush !== m_flush()) begin
                errors++;
                $display("FAIL random n=%0d pc=%h pt=%b tgt=%h fl=%b req %h %b %h %b", n, pc, pred_taken,
                         pred_target, flush, m_pc, m_pred_taken(m_pc), m_pred_target(m_pc), m_flush());
            end
            tick();
        end
        rst = 0; stall = 0; clear_ex();
    endtask

    initial begin
        m_pc = 16'h0000;
        model_reset();
        rst = 1; stall = 0; clear_ex();
        test_reset();
        test_taken_alloc();
        test_not_taken();
        test_stall_redirect();
        test_wrap();
        test_cond_table();
        test_alias();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
